iniciador_calculo: RTL and testbench

Initiator side of the calculation core's inicio/pronto handshake. It accepts one operand set (A, B, C, K) from a host, drives it to the core and raises inicio. It then waits for pronto, captures resultado, and returns it to the host on a valid/accept interface. A watchdog guards against a core that never answers, and a counter tracks completed operations. It sits between the host logic (or a testbench sequencer) and the core.

---
 rtl/iniciador_calculo.sv | 116 +++++++++++
 tb/tb_iniciador_calculo.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/iniciador_calculo.sv
// Initiator for the calculation core's inicio/pronto handshake: takes one operand set
// from the host, starts the core, waits for pronto (or a timeout) and returns the result.
module iniciador_calculo #(
  parameter int LARG           = 16,
  parameter int LARG_K         = 8,
  parameter int TIMEOUT_CICLOS = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valido,
  output logic              cmd_pronto,
  input  logic [LARG-1:0]   cmd_A,
  input  logic [LARG-1:0]   cmd_B,
  input  logic [LARG-1:0]   cmd_C,
  input  logic [LARG_K-1:0] cmd_K,
  output logic [LARG-1:0]   A,
  output logic [LARG-1:0]   B,
  output logic [LARG-1:0]   C,
  output logic [LARG_K-1:0] K,
  output logic              inicio,
  input  logic              pronto,
  input  logic [LARG-1:0]   resultado,
  output logic              res_valido,
  input  logic              res_aceito,
  output logic [LARG-1:0]   res_dado,
  output logic              res_erro,
  output logic              ocupado,
  output logic [7:0]        contador_ops
);

  typedef enum logic [1:0] {OCIOSO, EMITE, LIBERA, ENTREGA} estado_t;

  localparam logic [7:0] LIMITE = 8'(TIMEOUT_CICLOS);

  estado_t    estado, prox;
  logic [7:0] watchdog;
  logic [7:0] wd_prox;
  logic       estouro;

  assign wd_prox = watchdog + 8'd1;
  assign estouro = (wd_prox == LIMITE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) estado <= OCIOSO;
    else     estado <= prox;
  end

  // pronto has priority over the watchdog; LIBERA waits for pronto to fall so a
  // level-held pronto cannot start a second completion.
  always_comb begin
    prox = estado;
    case (estado)
      OCIOSO:  if (cmd_valido)         prox = EMITE;
      EMITE:   if (pronto || estouro)  prox = LIBERA;
      LIBERA:  if (!pronto)            prox = ENTREGA;
      ENTREGA: if (res_aceito)         prox = OCIOSO;
      default:                         prox = OCIOSO;
    endcase
  end

  always_comb begin
    cmd_pronto = (estado == OCIOSO);
    ocupado    = (estado != OCIOSO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      A            <= '0;
      B            <= '0;
      C            <= '0;
      K            <= '0;
      inicio       <= 1'b0;
      watchdog     <= '0;
      res_valido   <= 1'b0;
      res_dado     <= '0;
      res_erro     <= 1'b0;
      contador_ops <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (cmd_valido) begin
            A        <= cmd_A;
            B        <= cmd_B;
            C        <= cmd_C;
            K        <= cmd_K;
            inicio   <= 1'b1;
            watchdog <= '0;
          end
        end
        EMITE: begin
          watchdog <= wd_prox;
          if (pronto) begin
            res_dado <= resultado;
            res_erro <= 1'b0;
            inicio   <= 1'b0;
          end else if (estouro) begin
            res_dado <= '0;
            res_erro <= 1'b1;
            inicio   <= 1'b0;
          end
        end
        LIBERA: begin
          if (!pronto) res_valido <= 1'b1;
        end
        ENTREGA: begin
          if (res_aceito) begin
            res_valido   <= 1'b0;
            contador_ops <= contador_ops + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iniciador_calculo.sv
// Directed bench for iniciador_calculo: handshake, held pronto, timeout, backpressure,
// asynchronous reset mid-operation and counter wrap over 256 operations.
module tb_iniciador_calculo;

  localparam int LARG   = 16;
  localparam int LARG_K = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valido;
  logic              cmd_pronto;
  logic [LARG-1:0]   cmd_A, cmd_B, cmd_C;
  logic [LARG_K-1:0] cmd_K;
  logic [LARG-1:0]   A, B, C;
  logic [LARG_K-1:0] K;
  logic              inicio;
  logic              pronto;
  logic [LARG-1:0]   resultado;
  logic              res_valido;
  logic              res_aceito;
  logic [LARG-1:0]   res_dado;
  logic              res_erro;
  logic              ocupado;
  logic [7:0]        contador_ops;

  int compared   = 0;
  int mismatched = 0;

  iniciador_calculo #(.LARG(LARG), .LARG_K(LARG_K), .TIMEOUT_CICLOS(10)) dut (
    .clk(clk), .rst(rst),
    .cmd_valido(cmd_valido), .cmd_pronto(cmd_pronto),
    .cmd_A(cmd_A), .cmd_B(cmd_B), .cmd_C(cmd_C), .cmd_K(cmd_K),
    .A(A), .B(B), .C(C), .K(K),
    .inicio(inicio), .pronto(pronto), .resultado(resultado),
    .res_valido(res_valido), .res_aceito(res_aceito),
    .res_dado(res_dado), .res_erro(res_erro),
    .ocupado(ocupado), .contador_ops(contador_ops)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [7:0] k);
    cmd_A = a; cmd_B = b; cmd_C = c; cmd_K = k;
    cmd_valido = 1'b1;
  endtask

  initial begin
    rst = 1'b1; cmd_valido = 1'b0; cmd_A = '0; cmd_B = '0; cmd_C = '0; cmd_K = '0;
    pronto = 1'b0; resultado = '0; res_aceito = 1'b0;
    #3;
    check("rst_inicio", 32'(inicio), 32'd0);
    check("rst_res_valido", 32'(res_valido), 32'd0);
    check("rst_contador", 32'(contador_ops), 32'd0);
    check("rst_A", 32'(A), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("idle_cmd_pronto", 32'(cmd_pronto), 32'd1);
    check("idle_ocupado", 32'(ocupado), 32'd0);

    // Basic handshake: pronto 5 cycles after inicio
    send_cmd(16'd3, 16'd4, 16'd6, 8'd8);
    tick();
    cmd_valido = 1'b0;
    check("basic_inicio", 32'(inicio), 32'd1);
    check("basic_cmd_pronto", 32'(cmd_pronto), 32'd0);
    check("basic_ocupado", 32'(ocupado), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("basic_A", 32'(A), 32'd3);
      check("basic_B", 32'(B), 32'd4);
      check("basic_C", 32'(C), 32'd6);
      check("basic_K", 32'(K), 32'd8);
      check("basic_inicio_hold", 32'(inicio), 32'd1);
      tick();
    end
    pronto = 1'b1; resultado = 16'h0012;
    tick();
    pronto = 1'b0; resultado = 16'hdead;
    check("basic_inicio_drop", 32'(inicio), 32'd0);
    check("basic_no_valid_yet", 32'(res_valido), 32'd0);
    tick();
    check("basic_res_valido", 32'(res_valido), 32'd1);
    check("basic_res_dado", 32'(res_dado), 32'h0012);
    check("basic_res_erro", 32'(res_erro), 32'd0);
    res_aceito = 1'b1;
    tick();
    res_aceito = 1'b0;
    check("basic_valido_clr", 32'(res_valido), 32'd0);
    check("basic_contador", 32'(contador_ops), 32'd1);
    check("basic_cmd_pronto_back", 32'(cmd_pronto), 32'd1);

    // Level-held pronto for 4 cycles
    send_cmd(16'h0101, 16'h0202, 16'h0303, 8'h04);
    tick();
    cmd_valido = 1'b0;
    pronto = 1'b1; resultado = 16'h0055;
    tick();
    check("held_inicio_drop", 32'(inicio), 32'd0);
    check("held_res_valido0", 32'(res_valido), 32'd0);
    resultado = 16'h0077;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("held_wait_valido", 32'(res_valido), 32'd0);
      check("held_wait_inicio", 32'(inicio), 32'd0);
    end
    pronto = 1'b0;
    tick();
    check("held_res_valido", 32'(res_valido), 32'd1);
    check("held_res_dado", 32'(res_dado), 32'h0055);
    res_aceito = 1'b1;
    tick();
    res_aceito = 1'b0;
    check("held_contador", 32'(contador_ops), 32'd2);
    tick(); tick();
    check("held_single_count", 32'(contador_ops), 32'd2);
    check("held_idle", 32'(cmd_pronto), 32'd1);

    // Timeout: no pronto, TIMEOUT_CICLOS=10
    send_cmd(16'h00aa, 16'h00bb, 16'h00cc, 8'hdd);
    tick();
    cmd_valido = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("to_inicio_high", 32'(inicio), 32'd1);
      tick();
    end
    check("to_inicio_drop", 32'(inicio), 32'd0);
    tick();
    check("to_res_valido", 32'(res_valido), 32'd1);
    check("to_res_erro", 32'(res_erro), 32'd1);
    check("to_res_dado", 32'(res_dado), 32'd0);

    // Backpressure with a competing command presented
    send_cmd(16'h1111, 16'h2222, 16'h3333, 8'h44);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_res_valido", 32'(res_valido), 32'd1);
      check("bp_res_erro", 32'(res_erro), 32'd1);
      check("bp_res_dado", 32'(res_dado), 32'd0);
      check("bp_cmd_pronto", 32'(cmd_pronto), 32'd0);
      check("bp_A_stable", 32'(A), 32'h00aa);
      check("bp_inicio", 32'(inicio), 32'd0);
    end
    cmd_valido = 1'b0;
    res_aceito = 1'b1;
    tick();
    res_aceito = 1'b0;
    check("bp_valido_clr", 32'(res_valido), 32'd0);
    check("bp_cmd_pronto_back", 32'(cmd_pronto), 32'd1);
    check("to_contador", 32'(contador_ops), 32'd3);

    // Reset while in EMITE
    send_cmd(16'h5a5a, 16'h6b6b, 16'h7c7c, 8'h8d);
    tick();
    cmd_valido = 1'b0;
    tick(); tick();
    check("mid_pre_inicio", 32'(inicio), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_inicio", 32'(inicio), 32'd0);
    check("mid_A", 32'(A), 32'd0);
    check("mid_K", 32'(K), 32'd0);
    check("mid_contador", 32'(contador_ops), 32'd0);
    check("mid_res_erro", 32'(res_erro), 32'd0);
    check("mid_cmd_pronto", 32'(cmd_pronto), 32'd1);
    check("mid_ocupado", 32'(ocupado), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // 256 back-to-back minimum round trips
    for (int i = 0; i < 256; i++) begin
      send_cmd(16'(i), 16'(i + 1), 16'(i + 2), 8'(i));
      tick();
      cmd_valido = 1'b0;
      check("wrap_inicio", 32'(inicio), 32'd1);
      check("wrap_A", 32'(A), 32'(16'(i)));
      pronto = 1'b1; resultado = 16'(i) ^ 16'ha5a5;
      tick();
      pronto = 1'b0;
      tick();
      check("wrap_res_valido", 32'(res_valido), 32'd1);
      check("wrap_res_dado", 32'(res_dado), 32'(16'(i) ^ 16'ha5a5));
      res_aceito = 1'b1;
      tick();
      res_aceito = 1'b0;
      check("wrap_cmd_pronto", 32'(cmd_pronto), 32'd1);
      check("wrap_contador", 32'(contador_ops), 32'((i + 1) % 256));
    end
    check("wrap_final_zero", 32'(contador_ops), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
